// File: rtl/apb_req_bridge.sv
// Host valid/ready request queue feeding a single APB requester, with a valid/ready response port.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_req_bridge #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_write,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [ADDR_W-1:0]          PADDR,
   output logic [DATA_W-1:0]          PWDATA,
   input  logic [DATA_W-1:0]          PRDATA,
   input  logic                       PREADY
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   mem_addr  [DEPTH];
   logic [DATA_W-1:0]   mem_wdata [DEPTH];
   logic                mem_write [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic                push;
   logic                pop;

   // Full means not ready, even if a pop happens in the same cycle.
   assign req_ready = (level != LVL_W'(DEPTH));
   assign push      = req_valid & req_ready;
   assign pop       = (level != '0) &&
                      ((state == StIdle) || ((state == StResp) && rsp_ready));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level <= level + LVL_W'(1);
         else if (pop && !push) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (push) begin
         mem_addr[wr_ptr]  <= req_addr;
         mem_wdata[wr_ptr] <= req_wdata;
         mem_write[wr_ptr] <= req_write;
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= StIdle;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
         rsp_err   <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         case (state)
            StIdle: ;
            StSetup: begin
               PENABLE <= 1'b1;
               state   <= StAccess;
`ifdef APB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            StAccess: begin
`ifdef APB_TIMEOUT_EN
               // Watchdog expiry wins over a late PREADY on the abort edge.
               if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= PWRITE;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= StResp;
               end else
`endif
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= PWRITE;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= StResp;
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase

         // Head entry load overrides the IDLE/RESP outcome above.
         if (pop) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= mem_addr[rd_ptr];
            PWRITE  <= mem_write[rd_ptr];
            PWDATA  <= mem_write[rd_ptr] ? mem_wdata[rd_ptr] : '0;
            state   <= StSetup;
         end
      end
   end

endmodule

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
- Upstream command stage that feeds the APB bus.
- Accepts read/write requests from a host-side valid/ready port and buffers them in a DEPTH-entry FIFO.
- Sequences each request as a full APB transfer (SETUP, then ACCESS with PREADY wait states).
- Returns read data / completion on a valid/ready response port.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- DEPTH, 4, request FIFO entries; power of 2, at least 2.
- TIMEOUT, 16, max ACCESS cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  bus clock; all state on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  FIFO can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_write  out  1  echo of completed request type.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted (timeout).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB completer ready.

Behaviour:
- Reset (PRESETn low, asynchronous) clears all state immediately:
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - rsp_valid, rsp_write, rsp_rdata, rsp_err = 0.
  - level = 0; FIFO pointers = 0.
  - req_ready = 1 (FIFO empty), but no push occurs while PRESETn is low.
- Reset mid-transfer: in-flight and queued requests are discarded; no response is issued for them.
- FIFO:
  - Push when req_valid & req_ready; req_ready = (level != DEPTH).
  - When full, req_ready = 0 even if a pop occurs that cycle; no push-through.
  - Read/write pointers wrap modulo DEPTH.
  - level increments on push, decrements on pop, unchanged when both occur in the same cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if level != 0, pop the head entry into the transfer register and go to SETUP. Otherwise stay.
  - SETUP (one cycle): PSEL = 1, PENABLE = 0; PADDR/PWRITE from the entry; PWDATA = wdata for writes, 0 for reads. Always goes to ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1. PADDR/PWRITE/PWDATA held stable.
    - If PREADY = 1 is sampled: capture PRDATA (reads) into rsp_rdata, deassert PSEL/PENABLE, set rsp_valid = 1, go to RESP.
    - Otherwise stay in ACCESS (wait state).
  - RESP: rsp_valid held with stable rsp_* until rsp_ready = 1.
    - On handshake, if level != 0: pop the next entry and go directly to SETUP. Otherwise go to IDLE.
    - PSEL stays 0 throughout RESP.
- Latency, zero wait states, empty FIFO:
  - Request accepted at edge 0.
  - PSEL rises after edge 1.
  - PENABLE rises after edge 2.
  - rsp_valid rises after edge 3.
  - Each PREADY-low cycle adds one cycle.
- PADDR/PWDATA hold their last values while idle; only PSEL/PENABLE return to 0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter resets on entry to ACCESS and increments every ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT, the next edge deasserts PSEL/PENABLE and enters RESP with rsp_err = 1 and rsp_rdata = 0.
  - The queue is not flushed.
- Not defined: no counter logic; ACCESS waits indefinitely for PREADY; rsp_err tied 0.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with PREADY = 1:
  - PSEL/PENABLE/PWRITE/PADDR/PWDATA follow the SETUP-then-ACCESS sequence.
  - rsp_valid 3 cycles after accept, with rsp_write = 1 and rsp_rdata = 0.
- Read addr 0x10 with PRDATA = 0xCAFEF00D and PREADY low for 2 cycles:
  - PENABLE high for 3 cycles, address stable throughout.
  - rsp_rdata = 0xCAFEF00D, rsp_valid 5 cycles after accept.
- Push 5 requests back-to-back with DEPTH = 4 and PREADY = 0:
  - req_ready = 0 once level = 4, after the first entry is popped.
  - Once PREADY = 1 and responses are accepted, all 5 complete in order with no loss; level returns to 0.
- rsp_ready held 0 for 4 cycles with 2 requests queued: rsp_* stable, PSEL = 0; second transfer SETUP on the cycle after the handshake.
- Assert PRESETn low during ACCESS: all outputs 0 immediately, level = 0, no response afterwards; a new request after release completes normally.
- APB_TIMEOUT_EN, TIMEOUT = 16, PREADY stuck 0: abort after 16 ACCESS cycles with rsp_err = 1, rsp_rdata = 0; the next queued request proceeds.
